// File: rtl/wb_mailbox16_pkg.sv
// Shared definitions for the mailbox: register map, STATUS/CTRL bit positions,
// ack FSM states and the STATUS word layout.
package wb_mailbox16_pkg;

    localparam int DEPTH_LOG2_DEF = 4;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_OVF = 4;
    localparam int ST_UDF = 5;

    localparam int CT_RX_IE  = 0;
    localparam int CT_TXE_IE = 1;
    localparam int CT_OVF_IE = 2;

    typedef enum logic {S_IDLE, S_ACK} ack_state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] adr;
        logic [1:0] sel;
        logic [15:0] wdat;
    } bus_req_t;

    typedef struct packed {
        logic       rx_ne;
        logic       rx_full;
        logic       tx_full;
        logic       tx_empty;
        logic       ovf;
        logic       udf;
        logic [7:0] rx_occ;
    } status_t;

    function automatic logic [15:0] pack_status(input status_t s);
        return {s.rx_occ, 2'b00, s.udf, s.ovf, s.tx_empty, s.tx_full, s.rx_full, s.rx_ne};
    endfunction

endpackage

// File: rtl/sync_fifo16.sv
// 16-bit synchronous FIFO with wrap-bit pointers; head reads as zero when empty.
// Callers gate push/pop so push never overflows and pop never underflows.
module sync_fifo16 #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [15:0]           din,
    output logic [15:0]           dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // On full with a simultaneous pop, the write lands in the slot being
    // vacated; the pop still sees the old word because both are registered.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/wb_mailbox16.sv
// Wishbone B3 classic 16-bit mailbox: RX/TX FIFOs between the CPU and a
// side-band peripheral, with sticky error flags, CTRL enables and a level irq.
module wb_mailbox16
    import wb_mailbox16_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic        rx_valid_i,
    input  logic [15:0] rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [15:0] tx_data_o,
    input  logic        tx_ready_i,
    output logic        irq_o
);
    ack_state_t state, state_nx;
    logic       take;
    bus_req_t   req;

    logic bus_wr_data, bus_rd_data, bus_wr_status, bus_wr_ctrl;

    logic                rx_push, rx_pop, rx_full, rx_empty;
    logic [15:0]         rx_head;
    logic [DEPTH_LOG2:0] rx_count;
    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic [15:0]         tx_head;
    logic [DEPTH_LOG2:0] tx_count;

    logic        ovf, udf, ovf_set, udf_set;
    logic [7:0]  ctrl;
    logic [15:0] rdata;
    status_t     st;
    logic        unused_ok;

    assign unused_ok = ^{wb_adr_i[31:3], wb_adr_i[0], wb_sel_i[1], tx_count};

    assign req = '{we: wb_we_i, adr: wb_adr_i[2:1], sel: wb_sel_i, wdat: wb_dat_i};

    // A request is taken only from IDLE, so the ack cycle itself never
    // re-triggers and back-to-back strobes are acked every other cycle.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    take     = 1'b1;
                    state_nx = S_ACK;
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus_wr_data   = take &&  req.we && (req.adr == REG_DATA);
    assign bus_rd_data   = take && !req.we && (req.adr == REG_DATA);
    assign bus_wr_status = take &&  req.we && (req.adr == REG_STATUS);
    assign bus_wr_ctrl   = take &&  req.we && (req.adr == REG_CTRL);

    assign tx_pop  = !tx_empty && tx_ready_i;
    assign tx_push = bus_wr_data && (!tx_full || tx_pop);
    assign ovf_set = bus_wr_data && tx_full && !tx_pop;

    assign rx_pop  = bus_rd_data && !rx_empty;
    assign udf_set = bus_rd_data && rx_empty;
    // A full RX can still accept a side word in the cycle the CPU pops it.
    assign rx_ready_o = !rx_full || rx_pop;
    assign rx_push    = rx_valid_i && rx_ready_o;

    sync_fifo16 #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data_i),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo16 #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (req.wdat),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_valid_o = !tx_empty;
    assign tx_data_o  = tx_head;

    assign st = '{rx_ne:    !rx_empty,
                  rx_full:  rx_full,
                  tx_full:  tx_full,
                  tx_empty: tx_empty,
                  ovf:      ovf,
                  udf:      udf,
                  rx_occ:   8'(rx_count)};

    always_comb begin
        rdata = '0;
        case (req.adr)
            REG_DATA:   rdata = rx_head;
            REG_STATUS: rdata = pack_status(st);
            REG_CTRL:   rdata = {8'h00, ctrl};
            REG_RSVD:   rdata = '0;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            ctrl     <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            state    <= state_nx;
            wb_ack_o <= take;
            wb_dat_o <= (take && !req.we) ? rdata : '0;
            if (bus_wr_ctrl && req.sel[0]) ctrl <= req.wdat[7:0];
            if (ovf_set)                                 ovf <= 1'b1;
            else if (bus_wr_status && req.wdat[ST_OVF])  ovf <= 1'b0;
            if (udf_set)                                 udf <= 1'b1;
            else if (bus_wr_status && req.wdat[ST_UDF])  udf <= 1'b0;
            irq_o <= (ctrl[CT_RX_IE]  && !rx_empty) ||
                     (ctrl[CT_TXE_IE] && tx_empty)  ||
                     (ctrl[CT_OVF_IE] && (ovf || udf));
        end
    end

endmodule

// File: tb/tb_wb_mailbox16.sv
// Directed bench for wb_mailbox16: register table plus hand-written FIFO,
// flag, irq and bus-timing sequences with hand-computed expectations.
module tb_wb_mailbox16;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
    logic        rx_valid_i, rx_ready_o, tx_valid_o, tx_ready_i, irq_o;
    logic [15:0] rx_data_i, tx_data_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    wb_mailbox16 #(.DEPTH_LOG2(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .irq_o(irq_o)
    );

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [15:0] wdat;
        logic [1:0]  sel;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One classic cycle: drive at negedge, expect ack exactly one cycle later,
    // drop strobe in the ack cycle, expect ack low again the cycle after.
    task automatic bus(input logic we, input logic [1:0] adr, input logic [15:0] wdat,
                       input logic [1:0] sel, input logic txp, input logic rxp,
                       input logic [15:0] rxd, output logic [15:0] rdat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {29'd0, adr, 1'b0}; wb_dat_i = wdat; wb_sel_i = sel;
        tx_ready_i = txp; rx_valid_i = rxp; rx_data_i = rxd;
        check("ack_before_edge", wb_ack_o, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("ack_one_cycle", wb_ack_o, 1'b1);
        rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tx_ready_i = 1'b0; rx_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("ack_single", wb_ack_o, 1'b0);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [15:0] d);
        logic [15:0] r;
        bus(1'b1, adr, d, 2'b11, 1'b0, 1'b0, 16'h0, r);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] adr, input logic [15:0] exp);
        logic [15:0] r;
        bus(1'b0, adr, 16'h0, 2'b11, 1'b0, 1'b0, 16'h0, r);
        check(nm, r, exp);
    endtask

    task automatic rx_push_n(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            rx_valid_i = 1'b1;
            rx_data_i  = base + 16'(i);
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [15:0] r;
        logic [15:0] e;

        vecs[0] = '{1'b0, 2'd1, 16'h0000, 2'b11, 16'h0008};
        vecs[1] = '{1'b1, 2'd2, 16'h00FF, 2'b10, 16'h0000};
        vecs[2] = '{1'b0, 2'd2, 16'h0000, 2'b11, 16'h0000};
        vecs[3] = '{1'b1, 2'd2, 16'hFF05, 2'b01, 16'h0000};
        vecs[4] = '{1'b0, 2'd2, 16'h0000, 2'b11, 16'h0005};
        vecs[5] = '{1'b1, 2'd2, 16'h0000, 2'b11, 16'h0000};
        vecs[6] = '{1'b0, 2'd3, 16'h0000, 2'b11, 16'h0000};
        vecs[7] = '{1'b1, 2'd3, 16'hFFFF, 2'b11, 16'h0000};
        vecs[8] = '{1'b0, 2'd3, 16'h0000, 2'b11, 16'h0000};
        vecs[9] = '{1'b0, 2'd2, 16'h0000, 2'b11, 16'h0000};

        rst_i = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rx_valid_i = 1'b0; rx_data_i = '0; tx_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat", wb_dat_o, 16'h0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_rx_ready", rx_ready_o, 1'b1);
        check("rst_tx_valid", tx_valid_o, 1'b0);
        check("rst_tx_data", tx_data_o, 16'h0);
        rst_i = 1'b0;

        // Register map table
        foreach (vecs[i]) begin
            bus(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel, 1'b0, 1'b0, 16'h0, r);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
        end

        // TX path
        wr(2'd0, 16'h1234);
        wr(2'd0, 16'hBEEF);
        check("tx_valid_2", tx_valid_o, 1'b1);
        check("tx_head_1234", tx_data_o, 16'h1234);
        rd_chk("status_tx2", 2'd1, 16'h0000);
        @(negedge clk_i); tx_ready_i = 1'b1;
        @(negedge clk_i);
        check("tx_head_beef", tx_data_o, 16'hBEEF);
        check("tx_valid_1", tx_valid_o, 1'b1);
        @(negedge clk_i); tx_ready_i = 1'b0;
        check("tx_valid_0", tx_valid_o, 1'b0);
        check("tx_data_0", tx_data_o, 16'h0);

        // RX fill, drain, underflow
        wr(2'd0, 16'h5555);
        rx_push_n(16'h0000, 16);
        check("rx_ready_full", rx_ready_o, 1'b0);
        rd_chk("status_rx_full", 2'd1, 16'h1003);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("rx_rd%0d", i), 2'd0, 16'(i));
        rd_chk("rx_rd_empty", 2'd0, 16'h0000);
        rd_chk("status_udf", 2'd1, 16'h0020);
        wr(2'd1, 16'h0020);
        rd_chk("status_udf_clr", 2'd1, 16'h0000);
        @(negedge clk_i);
        check("tx_head_5555", tx_data_o, 16'h5555);
        tx_ready_i = 1'b1;
        @(negedge clk_i); tx_ready_i = 1'b0;
        check("tx_drained", tx_valid_o, 1'b0);

        // TX overflow, ovf irq, clear, push on full with pop
        for (int i = 0; i < 16; i++) wr(2'd0, 16'h0100 + 16'(i));
        rd_chk("status_tx_full", 2'd1, 16'h0004);
        wr(2'd0, 16'hDEAD);
        rd_chk("status_ovf", 2'd1, 16'h0014);
        wr(2'd2, 16'h0004);
        check("irq_ovf", irq_o, 1'b1);
        wr(2'd1, 16'h0010);
        check("irq_clr", irq_o, 1'b0);
        rd_chk("status_ovf_clr", 2'd1, 16'h0004);
        bus(1'b1, 2'd0, 16'hCAFE, 2'b11, 1'b1, 1'b0, 16'h0, r);
        rd_chk("status_full_pushpop", 2'd1, 16'h0004);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            e = (i == 15) ? 16'hCAFE : 16'h0101 + 16'(i);
            check($sformatf("tx_drain%0d", i), tx_data_o, e);
            tx_ready_i = 1'b1;
        end
        @(negedge clk_i); tx_ready_i = 1'b0;
        check("tx_empty_after", tx_valid_o, 1'b0);
        wr(2'd2, 16'h0000);

        // RX full: CPU pop and side push in the same cycle
        rx_push_n(16'h0020, 16);
        check("rx_ready_full2", rx_ready_o, 1'b0);
        bus(1'b0, 2'd0, 16'h0, 2'b11, 1'b0, 1'b1, 16'h0AAA, r);
        check("rx_pushpop_head", r, 16'h0020);
        rd_chk("status_still_full", 2'd1, 16'h100B);
        for (int i = 1; i < 16; i++) rd_chk($sformatf("rx2_rd%0d", i), 2'd0, 16'h0020 + 16'(i));
        rd_chk("rx_tail_new", 2'd0, 16'h0AAA);

        // Back-to-back strobe: ack every second cycle
        rx_push_n(16'h0031, 3);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check($sformatf("b2b_ack%0d", k), wb_ack_o, (k % 2) == 0);
            if (k % 2 == 0) check($sformatf("b2b_dat%0d", k), wb_dat_o, 16'h0031 + 16'(k / 2));
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check("b2b_end_ack", wb_ack_o, 1'b0);
        rd_chk("status_b2b", 2'd1, 16'h0008);

        // cyc drops before the edge: no ack, no pop
        rx_push_n(16'h0077, 1);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h0;
        #2;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check("abort_ack", wb_ack_o, 1'b0);
        rd_chk("status_abort", 2'd1, 16'h0109);
        rd_chk("abort_word_kept", 2'd0, 16'h0077);

        // Reset mid-transaction
        rx_push_n(16'h0099, 1);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h0;
        rst_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        check("rst_mid_ack", wb_ack_o, 1'b0);
        check("rst_mid_rx_ready", rx_ready_o, 1'b1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst_i = 1'b0;
        rd_chk("status_after_rst", 2'd1, 16'h0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
